wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. It shares the single write port between the WB
// stage and a small FIFO of long-latency aux writes, with a starvation guard.
module wb_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AUX_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wr_en,
    input  logic [3:0]  pipe_dest,
    input  logic [31:0] pipe_data,
    input  logic        aux_valid,
    input  logic [3:0]  aux_dest,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    output logic        rf_wr_en,
    output logic [3:0]  rf_dest,
    output logic [31:0] rf_data,
    output logic        pipe_stall,
    output logic [15:0] pending_mask
);

    localparam int unsigned PTR_W = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(AUX_DEPTH + 1);
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        NORMAL,
        FORCE
    } state_t;

    state_t               state, state_next;
    logic [SC_W-1:0]      starve_cnt, starve_next;
    logic [CNT_W-1:0]     count;
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [AUX_DEPTH-1:0] valid;
    logic [3:0]           buf_dest [AUX_DEPTH];
    logic [31:0]          buf_data [AUX_DEPTH];

    logic buf_empty;
    logic grant_pipe;
    logic grant_aux;
    logic push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(AUX_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign buf_empty  = (count == '0);
    assign aux_ready  = (count < CNT_W'(AUX_DEPTH));
    assign push       = aux_valid && aux_ready;
    assign pipe_stall = (state == FORCE);

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        grant_pipe  = 1'b0;
        grant_aux   = 1'b0;
        case (state)
            NORMAL: begin
                if (pipe_wr_en)
                    grant_pipe = 1'b1;
                else if (!buf_empty)
                    grant_aux = 1'b1;

                if (buf_empty || grant_aux) begin
                    starve_next = '0;
                end else if (starve_cnt == SC_W'(STARVE_MAX - 1)) begin
                    starve_next = SC_W'(STARVE_MAX);
                    state_next  = FORCE;
                end else begin
                    starve_next = starve_cnt + SC_W'(1);
                end
            end
            FORCE: begin
                grant_aux   = !buf_empty;
                starve_next = '0;
                state_next  = NORMAL;
            end
            default: begin
                state_next  = NORMAL;
                starve_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            valid      <= '0;
            rf_wr_en   <= 1'b0;
            rf_dest    <= '0;
            rf_data    <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;

            if (push) begin
                buf_dest[wr_ptr] <= aux_dest;
                buf_data[wr_ptr] <= aux_data;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (grant_aux)
                rd_ptr <= ptr_inc(rd_ptr);

            // Push and pop never target the same slot: that needs count 0 (no pop) or full (no push).
            if (grant_aux)
                valid[rd_ptr] <= 1'b0;
            if (push)
                valid[wr_ptr] <= 1'b1;

            case ({push, grant_aux})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (grant_pipe) begin
                rf_wr_en <= 1'b1;
                rf_dest  <= pipe_dest;
                rf_data  <= pipe_data;
            end else if (grant_aux) begin
                rf_wr_en <= 1'b1;
                rf_dest  <= buf_dest[rd_ptr];
                rf_data  <= buf_data[rd_ptr];
            end else begin
                rf_wr_en <= 1'b0;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < AUX_DEPTH; i++) begin
            if (valid[PTR_W'(i)])
                pending_mask[buf_dest[PTR_W'(i)]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter. Expected register-file writes are queued as
// stimulus is driven, and a negedge monitor retires them in order.
module tb_wb_port_arbiter;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wr_en;
    logic [3:0]  pipe_dest;
    logic [31:0] pipe_data;
    logic        aux_valid;
    logic [3:0]  aux_dest;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        rf_wr_en;
    logic [3:0]  rf_dest;
    logic [31:0] rf_data;
    logic        pipe_stall;
    logic [15:0] pending_mask;

    int   n_checks = 0;
    int   n_pass   = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;

    wb_port_arbiter #(
        .STARVE_MAX(4),
        .AUX_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_wr_en  (pipe_wr_en),
        .pipe_dest   (pipe_dest),
        .pipe_data   (pipe_data),
        .aux_valid   (aux_valid),
        .aux_dest    (aux_dest),
        .aux_data    (aux_data),
        .aux_ready   (aux_ready),
        .rf_wr_en    (rf_wr_en),
        .rf_dest     (rf_dest),
        .rf_data     (rf_data),
        .pipe_stall  (pipe_stall),
        .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [3:0] d, input logic [31:0] v);
        wr_t e;
        e.dest = d;
        e.data = v;
        exp_q.push_back(e);
    endtask

    // Every cycle with rf_wr_en high is one register-file write; it must match the queue head.
    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(rf_dest), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_dest", 32'(rf_dest), 32'(mon_e.dest));
                check("sb_data", rf_data, mon_e.data);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        pipe_wr_en = 1'b0;
        pipe_dest  = '0;
        pipe_data  = '0;
        aux_valid  = 1'b0;
        aux_dest   = '0;
        aux_data   = '0;
        tick();
        tick();
        check("rst_wr_en", 32'(rf_wr_en), 32'd0);
        check("rst_dest", 32'(rf_dest), 32'd0);
        check("rst_data", rf_data, 32'd0);
        check("rst_stall", 32'(pipe_stall), 32'd0);
        check("rst_ready", 32'(aux_ready), 32'd1);
        check("rst_mask", 32'(pending_mask), 32'd0);
        rst = 1'b0;
        tick();

        // Pipe-only write, latency one
        pipe_wr_en = 1'b1;
        pipe_dest  = 4'd3;
        pipe_data  = 32'hDEAD_BEEF;
        expect_wr(4'd3, 32'hDEAD_BEEF);
        check("pipe_stall0", 32'(pipe_stall), 32'd0);
        tick();
        pipe_wr_en = 1'b0;
        check("pipe_wr_en", 32'(rf_wr_en), 32'd1);
        check("pipe_dest", 32'(rf_dest), 32'd3);
        check("pipe_data", rf_data, 32'hDEAD_BEEF);
        check("pipe_stall1", 32'(pipe_stall), 32'd0);
        tick();
        check("idle_wr_en", 32'(rf_wr_en), 32'd0);
        check("idle_hold_dest", 32'(rf_dest), 32'd3);
        check("idle_hold_data", rf_data, 32'hDEAD_BEEF);

        // Aux into idle port
        aux_valid = 1'b1;
        aux_dest  = 4'd5;
        aux_data  = 32'h12;
        check("aux_ready_idle", 32'(aux_ready), 32'd1);
        expect_wr(4'd5, 32'h12);
        tick();
        aux_valid = 1'b0;
        check("aux_mask_buffered", 32'(pending_mask), 32'h0020);
        check("aux_no_bypass", 32'(rf_wr_en), 32'd0);
        tick();
        check("aux_wr_en", 32'(rf_wr_en), 32'd1);
        check("aux_dest", 32'(rf_dest), 32'd5);
        check("aux_data", rf_data, 32'h12);
        check("aux_mask_drained", 32'(pending_mask), 32'd0);

        // Starvation: aux pushed in cycle 0, pipe busy every cycle
        pipe_wr_en = 1'b1;
        pipe_dest  = 4'd1;
        for (int c = 0; c < 5; c++) begin
            pipe_data = 32'h100 + 32'(c);
            aux_valid = (c == 0);
            aux_dest  = 4'd7;
            aux_data  = 32'hA5A5;
            expect_wr(4'd1, 32'h100 + 32'(c));
            check("starve_no_stall", 32'(pipe_stall), 32'd0);
            if (c == 3)
                check("starve_mask", 32'(pending_mask), 32'h0080);
            tick();
        end
        aux_valid = 1'b0;
        pipe_data = 32'h105;
        check("starve_stall", 32'(pipe_stall), 32'd1);
        expect_wr(4'd7, 32'hA5A5);
        tick();
        check("starve_forced_dest", 32'(rf_dest), 32'd7);
        check("starve_forced_data", rf_data, 32'hA5A5);
        check("starve_released", 32'(pipe_stall), 32'd0);
        expect_wr(4'd1, 32'h105);
        tick();
        pipe_wr_en = 1'b0;
        check("starve_resume_data", rf_data, 32'h105);
        tick();

        // Full buffer: a pop does not make a full buffer ready in the same cycle
        pipe_wr_en = 1'b1;
        pipe_dest  = 4'd1;
        pipe_data  = 32'h200;
        aux_valid  = 1'b1;
        aux_dest   = 4'd2;
        aux_data   = 32'h22;
        expect_wr(4'd1, 32'h200);
        check("full_ready0", 32'(aux_ready), 32'd1);
        tick();
        pipe_data = 32'h201;
        aux_dest  = 4'd4;
        aux_data  = 32'h44;
        expect_wr(4'd1, 32'h201);
        check("full_ready1", 32'(aux_ready), 32'd1);
        tick();
        pipe_wr_en = 1'b0;
        aux_dest   = 4'd6;
        aux_data   = 32'h66;
        check("full_not_ready", 32'(aux_ready), 32'd0);
        check("full_mask", 32'(pending_mask), 32'h0014);
        expect_wr(4'd2, 32'h22);
        tick();
        check("full_ready_after_pop", 32'(aux_ready), 32'd1);
        check("full_mask_after_pop", 32'(pending_mask), 32'h0010);
        expect_wr(4'd4, 32'h44);
        tick();
        aux_valid = 1'b0;
        check("full_mask_late_push", 32'(pending_mask), 32'h0040);
        expect_wr(4'd6, 32'h66);
        tick();
        check("full_drained_mask", 32'(pending_mask), 32'd0);
        check("full_drained_ready", 32'(aux_ready), 32'd1);
        tick();

        // Reset while FORCE with two buffered entries
        pipe_wr_en = 1'b1;
        pipe_dest  = 4'd1;
        for (int c = 0; c < 5; c++) begin
            pipe_data = 32'h300 + 32'(c);
            aux_valid = (c < 2);
            aux_dest  = (c == 0) ? 4'd8 : 4'd9;
            aux_data  = 32'h900 + 32'(c);
            expect_wr(4'd1, 32'h300 + 32'(c));
            tick();
        end
        aux_valid = 1'b0;
        check("rst2_stall", 32'(pipe_stall), 32'd1);
        check("rst2_full", 32'(aux_ready), 32'd0);
        check("rst2_mask", 32'(pending_mask), 32'h0300);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        pipe_wr_en = 1'b0;
        check("rst2_wr_en", 32'(rf_wr_en), 32'd0);
        check("rst2_dest", 32'(rf_dest), 32'd0);
        check("rst2_data", rf_data, 32'd0);
        check("rst2_unstall", 32'(pipe_stall), 32'd0);
        check("rst2_ready", 32'(aux_ready), 32'd1);
        check("rst2_mask_clear", 32'(pending_mask), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rst2_no_drain", 32'(rf_wr_en), 32'd0);
        end
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
